// File: rtl/gpu_ram_pkg.sv
// Shared types and widths for the GPU RAM arbiter: requester ids, operation codes
// and the read-return pipe entry.
package gpu_ram_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        PORT_A = 2'd0,
        PORT_B = 2'd1,
        PORT_C = 2'd2
    } port_id_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    typedef struct packed {
        logic     valid;
        port_id_t port;
    } ret_t;

    // Round-robin successor: A -> B -> C -> A.
    function automatic port_id_t next_port(input port_id_t p);
        case (p)
            PORT_A:  return PORT_B;
            PORT_B:  return PORT_C;
            default: return PORT_A;
        endcase
    endfunction

endpackage

// File: rtl/gpu_req_slot.sv
// One requester's pending slot: captures a single read or write pulse and holds
// it (busy) until the arbiter grants it.
module gpu_req_slot #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_ena,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              grant,
    output logic              busy,
    output logic              is_write,
    output logic [ADDR_W-1:0] slot_address,
    output logic [DATA_W-1:0] slot_data
);
    import gpu_ram_pkg::*;

    logic              full_q, full_d;
    op_t               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    // A full slot ignores new pulses; a simultaneous write and read keeps the write.
    always_comb begin
        full_d = full_q;
        op_d   = op_q;
        addr_d = addr_q;
        data_d = data_q;
        if (!full_q && (wr_ena || rd_req)) begin
            full_d = 1'b1;
            op_d   = wr_ena ? OP_WR : OP_RD;
            addr_d = address;
            data_d = data_in;
        end else if (full_q && grant) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            op_q   <= OP_RD;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            op_q   <= op_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign busy         = full_q;
    assign is_write     = (op_q == OP_WR);
    assign slot_address = addr_q;
    assign slot_data    = data_q;

endmodule

// File: rtl/gpu_ram_arbiter.sv
// Shares the single GPU RAM port between Z80 (A), RS232 (B) and blitter (C) with
// round-robin arbitration, and routes read data back after the RAM latency.
module gpu_ram_arbiter #(
    parameter int ADDR_W            = 20,
    parameter int DATA_W            = 8,
    parameter int READ_CLOCK_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_ena_a,
    input  logic              rd_req_a,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [DATA_W-1:0] data_in_a,
    output logic              busy_a,
    output logic              rd_rdy_a,
    output logic [DATA_W-1:0] data_out_a,
    input  logic              wr_ena_b,
    input  logic              rd_req_b,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] data_in_b,
    output logic              busy_b,
    output logic              rd_rdy_b,
    output logic [DATA_W-1:0] data_out_b,
    input  logic              wr_ena_c,
    input  logic              rd_req_c,
    input  logic [ADDR_W-1:0] address_c,
    input  logic [DATA_W-1:0] data_in_c,
    output logic              busy_c,
    output logic              rd_rdy_c,
    output logic [DATA_W-1:0] data_out_c,
    output logic              gpu_wr_ena,
    output logic              gpu_rd_ena,
    output logic [ADDR_W-1:0] gpu_address,
    output logic [DATA_W-1:0] gpu_data_out,
    input  logic [DATA_W-1:0] gpu_data_in
);
    import gpu_ram_pkg::*;

    logic [2:0]        full;
    logic [2:0]        grant;
    logic [2:0]        is_wr;
    logic [ADDR_W-1:0] s_addr [3];
    logic [DATA_W-1:0] s_data [3];

    gpu_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_a (
        .clk(clk), .reset(reset), .wr_ena(wr_ena_a), .rd_req(rd_req_a),
        .address(address_a), .data_in(data_in_a), .grant(grant[0]),
        .busy(full[0]), .is_write(is_wr[0]), .slot_address(s_addr[0]), .slot_data(s_data[0])
    );

    gpu_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_b (
        .clk(clk), .reset(reset), .wr_ena(wr_ena_b), .rd_req(rd_req_b),
        .address(address_b), .data_in(data_in_b), .grant(grant[1]),
        .busy(full[1]), .is_write(is_wr[1]), .slot_address(s_addr[1]), .slot_data(s_data[1])
    );

    gpu_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_c (
        .clk(clk), .reset(reset), .wr_ena(wr_ena_c), .rd_req(rd_req_c),
        .address(address_c), .data_in(data_in_c), .grant(grant[2]),
        .busy(full[2]), .is_write(is_wr[2]), .slot_address(s_addr[2]), .slot_data(s_data[2])
    );

    port_id_t          ptr_q, ptr_d;
    port_id_t          win_port, cand;
    logic              win_valid;
    logic              gpu_wr_ena_q, gpu_wr_ena_d;
    logic              gpu_rd_ena_q, gpu_rd_ena_d;
    logic [ADDR_W-1:0] gpu_address_q, gpu_address_d;
    logic [DATA_W-1:0] gpu_data_out_q, gpu_data_out_d;
    port_id_t          issue_port_q, issue_port_d;

    // First full slot at or after the pointer wins; the pointer then moves past it.
    always_comb begin
        win_valid = 1'b0;
        win_port  = ptr_q;
        cand      = ptr_q;
        for (int i = 0; i < 3; i++) begin
            if (!win_valid && full[cand]) begin
                win_valid = 1'b1;
                win_port  = cand;
            end
            cand = next_port(cand);
        end
        ptr_d = win_valid ? next_port(win_port) : ptr_q;
        grant = win_valid ? (3'b001 << win_port) : 3'b000;
    end

    always_comb begin
        gpu_wr_ena_d   = win_valid && is_wr[win_port];
        gpu_rd_ena_d   = win_valid && !is_wr[win_port];
        gpu_address_d  = win_valid ? s_addr[win_port] : gpu_address_q;
        gpu_data_out_d = win_valid ? s_data[win_port] : gpu_data_out_q;
        issue_port_d   = win_valid ? win_port : issue_port_q;
    end

    ret_t              pipe_q [READ_CLOCK_CYCLES];
    ret_t              pipe_d [READ_CLOCK_CYCLES];
    ret_t              ret_head;
    logic [2:0]        rd_rdy_q, rd_rdy_d;
    logic [DATA_W-1:0] data_out_q [3];
    logic [DATA_W-1:0] data_out_d [3];

    // The pipe tail lines up with gpu_data_in being valid for that read.
    always_comb begin
        pipe_d[0].valid = gpu_rd_ena_q;
        pipe_d[0].port  = issue_port_q;
        for (int i = 1; i < READ_CLOCK_CYCLES; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        ret_head = pipe_q[READ_CLOCK_CYCLES-1];
        rd_rdy_d = ret_head.valid ? (3'b001 << ret_head.port) : 3'b000;
        for (int k = 0; k < 3; k++) begin
            data_out_d[k] = rd_rdy_d[k] ? gpu_data_in : data_out_q[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q          <= PORT_A;
            gpu_wr_ena_q   <= 1'b0;
            gpu_rd_ena_q   <= 1'b0;
            gpu_address_q  <= '0;
            gpu_data_out_q <= '0;
            issue_port_q   <= PORT_A;
            rd_rdy_q       <= 3'b000;
            for (int i = 0; i < READ_CLOCK_CYCLES; i++) begin
                pipe_q[i] <= '0;
            end
            for (int k = 0; k < 3; k++) begin
                data_out_q[k] <= '0;
            end
        end else begin
            ptr_q          <= ptr_d;
            gpu_wr_ena_q   <= gpu_wr_ena_d;
            gpu_rd_ena_q   <= gpu_rd_ena_d;
            gpu_address_q  <= gpu_address_d;
            gpu_data_out_q <= gpu_data_out_d;
            issue_port_q   <= issue_port_d;
            rd_rdy_q       <= rd_rdy_d;
            for (int i = 0; i < READ_CLOCK_CYCLES; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            for (int k = 0; k < 3; k++) begin
                data_out_q[k] <= data_out_d[k];
            end
        end
    end

    assign busy_a       = full[0];
    assign busy_b       = full[1];
    assign busy_c       = full[2];
    assign rd_rdy_a     = rd_rdy_q[0];
    assign rd_rdy_b     = rd_rdy_q[1];
    assign rd_rdy_c     = rd_rdy_q[2];
    assign data_out_a   = data_out_q[0];
    assign data_out_b   = data_out_q[1];
    assign data_out_c   = data_out_q[2];
    assign gpu_wr_ena   = gpu_wr_ena_q;
    assign gpu_rd_ena   = gpu_rd_ena_q;
    assign gpu_address  = gpu_address_q;
    assign gpu_data_out = gpu_data_out_q;

endmodule

// File: tb/tb_gpu_ram_arbiter.sv
// Directed bench for gpu_ram_arbiter with a behavioural GPU RAM of fixed read latency.
module tb_gpu_ram_arbiter;

    localparam int AW  = 20;
    localparam int DW  = 8;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_ena_a = 0, rd_req_a = 0, wr_ena_b = 0, rd_req_b = 0, wr_ena_c = 0, rd_req_c = 0;
    logic [AW-1:0] address_a = '0, address_b = '0, address_c = '0;
    logic [DW-1:0] data_in_a = '0, data_in_b = '0, data_in_c = '0;
    logic          busy_a, busy_b, busy_c, rd_rdy_a, rd_rdy_b, rd_rdy_c;
    logic [DW-1:0] data_out_a, data_out_b, data_out_c;
    logic          gpu_wr_ena, gpu_rd_ena;
    logic [AW-1:0] gpu_address;
    logic [DW-1:0] gpu_data_out, gpu_data_in;

    int checks = 0;
    int errors = 0;

    gpu_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_CLOCK_CYCLES(LAT)) dut (
        .clk(clk), .reset(reset),
        .wr_ena_a(wr_ena_a), .rd_req_a(rd_req_a), .address_a(address_a), .data_in_a(data_in_a),
        .busy_a(busy_a), .rd_rdy_a(rd_rdy_a), .data_out_a(data_out_a),
        .wr_ena_b(wr_ena_b), .rd_req_b(rd_req_b), .address_b(address_b), .data_in_b(data_in_b),
        .busy_b(busy_b), .rd_rdy_b(rd_rdy_b), .data_out_b(data_out_b),
        .wr_ena_c(wr_ena_c), .rd_req_c(rd_req_c), .address_c(address_c), .data_in_c(data_in_c),
        .busy_c(busy_c), .rd_rdy_c(rd_rdy_c), .data_out_c(data_out_c),
        .gpu_wr_ena(gpu_wr_ena), .gpu_rd_ena(gpu_rd_ena), .gpu_address(gpu_address),
        .gpu_data_out(gpu_data_out), .gpu_data_in(gpu_data_in)
    );

    always #5 clk = ~clk;

    // RAM model: data for the address presented in cycle N appears in cycle N+LAT.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] apipe [LAT];

    always @(posedge clk) begin
        if (gpu_wr_ena) mem[gpu_address] <= gpu_data_out;
        apipe[0] <= gpu_address;
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end

    assign gpu_data_in = mem[apipe[LAT-1]];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses;
        wr_ena_a = 0; rd_req_a = 0; wr_ena_b = 0; rd_req_b = 0; wr_ena_c = 0; rd_req_c = 0;
    endtask

    task automatic do_reset;
        clear_pulses();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        logic [63:0] outs;
        clear_pulses();
        reset = 1'b1;
        #1;
        outs = {busy_a, busy_b, busy_c, rd_rdy_a, rd_rdy_b, rd_rdy_c, data_out_a, data_out_b,
                data_out_c, gpu_wr_ena, gpu_rd_ena, gpu_address, gpu_data_out};
        checks++;
        if (outs !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h want 0", outs);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_read;
        address_a = 20'h01234;
        rd_req_a  = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            clear_pulses();
            checks++;
            if (gpu_rd_ena !== (c == 2)) begin
                errors++;
                $display("[TB] FAIL t1_gpu_rd_ena c%0d got %b want %b", c, gpu_rd_ena, (c == 2));
            end
            checks++;
            if (rd_rdy_a !== (c == 5)) begin
                errors++;
                $display("[TB] FAIL t1_rd_rdy_a c%0d got %b want %b", c, rd_rdy_a, (c == 5));
            end
            checks++;
            if (busy_a !== (c == 1)) begin
                errors++;
                $display("[TB] FAIL t1_busy_a c%0d got %b want %b", c, busy_a, (c == 1));
            end
            if (c == 2) begin
                checks++;
                if (gpu_address !== 20'h01234) begin
                    errors++;
                    $display("[TB] FAIL t1_gpu_address got %h want 01234", gpu_address);
                end
            end
            if (c >= 5) begin
                checks++;
                if (data_out_a !== 8'h5A) begin
                    errors++;
                    $display("[TB] FAIL t1_data_out_a c%0d got %h want 5a", c, data_out_a);
                end
            end
        end
    endtask

    task automatic test_same_clock_writes;
        logic [AW-1:0] ea [3];
        logic [DW-1:0] ed [3];
        ea[0] = 20'h00010; ea[1] = 20'h00020; ea[2] = 20'h00030;
        ed[0] = 8'h11;     ed[1] = 8'h22;     ed[2] = 8'h33;
        do_reset();
        address_a = ea[0]; data_in_a = ed[0]; wr_ena_a = 1'b1;
        address_b = ea[1]; data_in_b = ed[1]; wr_ena_b = 1'b1;
        address_c = ea[2]; data_in_c = ed[2]; wr_ena_c = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            clear_pulses();
            checks++;
            if (gpu_wr_ena !== (c >= 2 && c <= 4)) begin
                errors++;
                $display("[TB] FAIL t2_gpu_wr_ena c%0d got %b want %b", c, gpu_wr_ena, (c >= 2 && c <= 4));
            end
            checks++;
            if (busy_c !== (c <= 3)) begin
                errors++;
                $display("[TB] FAIL t2_busy_c c%0d got %b want %b", c, busy_c, (c <= 3));
            end
            if (c >= 2 && c <= 4) begin
                checks++;
                if (gpu_address !== ea[c-2] || gpu_data_out !== ed[c-2]) begin
                    errors++;
                    $display("[TB] FAIL t2_order c%0d got %h/%h want %h/%h", c, gpu_address,
                             gpu_data_out, ea[c-2], ed[c-2]);
                end
            end
        end
    endtask

    // A lone A write leaves the pointer at B, so the following burst goes B, C, A.
    task automatic test_rr_rotation;
        logic [AW-1:0] ea [3];
        logic [DW-1:0] ed [3];
        ea[0] = 20'h00042; ea[1] = 20'h00043; ea[2] = 20'h00041;
        ed[0] = 8'hB2;     ed[1] = 8'hC3;     ed[2] = 8'hA1;
        address_a = 20'h00040; data_in_a = 8'h44; wr_ena_a = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            clear_pulses();
            if (c == 2) begin
                address_a = 20'h00041; data_in_a = 8'hA1; wr_ena_a = 1'b1;
                address_b = 20'h00042; data_in_b = 8'hB2; wr_ena_b = 1'b1;
                address_c = 20'h00043; data_in_c = 8'hC3; wr_ena_c = 1'b1;
                checks++;
                if (gpu_wr_ena !== 1'b1 || gpu_address !== 20'h00040) begin
                    errors++;
                    $display("[TB] FAIL t3_single got %b/%h want 1/00040", gpu_wr_ena, gpu_address);
                end
            end
            if (c == 3) begin
                checks++;
                if ({busy_a, busy_b, busy_c} !== 3'b111) begin
                    errors++;
                    $display("[TB] FAIL t3_busy got %b want 111", {busy_a, busy_b, busy_c});
                end
            end
            if (c == 3 || c == 7) begin
                checks++;
                if (gpu_wr_ena !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL t3_idle c%0d got %b want 0", c, gpu_wr_ena);
                end
            end
            if (c >= 4 && c <= 6) begin
                checks++;
                if (gpu_wr_ena !== 1'b1 || gpu_address !== ea[c-4] || gpu_data_out !== ed[c-4]) begin
                    errors++;
                    $display("[TB] FAIL t3_order c%0d got %b/%h/%h want 1/%h/%h", c, gpu_wr_ena,
                             gpu_address, gpu_data_out, ea[c-4], ed[c-4]);
                end
            end
        end
        checks++;
        if ({mem[20'h10], mem[20'h20], mem[20'h30], mem[20'h40], mem[20'h41], mem[20'h42], mem[20'h43]}
            !== 56'h11_22_33_44_A1_B2_C3) begin
            errors++;
            $display("[TB] FAIL t3_ram got %h %h %h %h %h %h %h want 11 22 33 44 a1 b2 c3",
                     mem[20'h10], mem[20'h20], mem[20'h30], mem[20'h40], mem[20'h41], mem[20'h42], mem[20'h43]);
        end
    endtask

    task automatic test_back_to_back_reads;
        address_b = 20'h00070; rd_req_b = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            clear_pulses();
            if (c == 1) begin
                address_c = 20'h00071; rd_req_c = 1'b1;
            end
            checks++;
            if (rd_rdy_a !== 1'b0) begin
                errors++;
                $display("[TB] FAIL t4_rd_rdy_a c%0d got %b want 0", c, rd_rdy_a);
            end
            checks++;
            if (rd_rdy_b !== (c == 5) || rd_rdy_c !== (c == 6)) begin
                errors++;
                $display("[TB] FAIL t4_rd_rdy_bc c%0d got %b%b want %b%b", c, rd_rdy_b, rd_rdy_c,
                         (c == 5), (c == 6));
            end
            if (c == 6) begin
                checks++;
                if (data_out_b !== 8'hAA || data_out_c !== 8'hBB) begin
                    errors++;
                    $display("[TB] FAIL t4_data got %h/%h want aa/bb", data_out_b, data_out_c);
                end
            end
        end
    endtask

    task automatic test_write_read_collision;
        int wr_count;
        int rd_count;
        wr_count = 0;
        rd_count = 0;
        address_b = 20'h00050; data_in_b = 8'h77; wr_ena_b = 1'b1; rd_req_b = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            clear_pulses();
            if (c == 1) begin
                checks++;
                if (busy_b !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL t5_busy_b got %b want 1", busy_b);
                end
                address_b = 20'h00060; data_in_b = 8'h99; wr_ena_b = 1'b1;
            end
            if (c == 2) begin
                checks++;
                if (gpu_address !== 20'h00050 || gpu_data_out !== 8'h77) begin
                    errors++;
                    $display("[TB] FAIL t5_issue got %h/%h want 00050/77", gpu_address, gpu_data_out);
                end
            end
            if (c == 3) begin
                checks++;
                if (busy_b !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL t5_busy_after got %b want 0", busy_b);
                end
            end
            wr_count += int'(gpu_wr_ena);
            rd_count += int'(gpu_rd_ena) + int'(rd_rdy_b);
        end
        checks++;
        if (wr_count != 1 || rd_count != 0) begin
            errors++;
            $display("[TB] FAIL t5_strobes got wr=%0d rd=%0d want wr=1 rd=0", wr_count, rd_count);
        end
        checks++;
        if (mem[20'h50] !== 8'h77 || mem[20'h60] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL t5_ram got %h/%h want 77/00", mem[20'h50], mem[20'h60]);
        end
    endtask

    task automatic test_reset_in_flight;
        logic [63:0] outs;
        address_c = 20'h00071; rd_req_c = 1'b1;
        tick();
        clear_pulses();
        tick();
        checks++;
        if (gpu_rd_ena !== 1'b1) begin
            errors++;
            $display("[TB] FAIL t6_gpu_rd_ena got %b want 1", gpu_rd_ena);
        end
        tick();
        reset = 1'b1;
        #1;
        outs = {busy_a, busy_b, busy_c, rd_rdy_a, rd_rdy_b, rd_rdy_c, data_out_a, data_out_b,
                data_out_c, gpu_wr_ena, gpu_rd_ena, gpu_address, gpu_data_out};
        checks++;
        if (outs !== 64'd0) begin
            errors++;
            $display("[TB] FAIL t6_reset_outputs got %h want 0", outs);
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if ({rd_rdy_a, rd_rdy_b, rd_rdy_c} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL t6_stale_rdy c%0d got %b want 000", c, {rd_rdy_a, rd_rdy_b, rd_rdy_c});
            end
        end
        address_c = 20'h00070; rd_req_c = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            clear_pulses();
            checks++;
            if (gpu_rd_ena !== (c == 2) || rd_rdy_c !== (c == 5)) begin
                errors++;
                $display("[TB] FAIL t6_after c%0d got rd_ena=%b rdy=%b want %b %b", c, gpu_rd_ena,
                         rd_rdy_c, (c == 2), (c == 5));
            end
        end
        checks++;
        if (data_out_c !== 8'hAA) begin
            errors++;
            $display("[TB] FAIL t6_data_out_c got %h want aa", data_out_c);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        for (int i = 0; i < LAT; i++) apipe[i] = '0;
        mem[20'h01234] = 8'h5A;
        mem[20'h00070] = 8'hAA;
        mem[20'h00071] = 8'hBB;
        #2;
        test_reset();
        test_single_read();
        test_same_clock_writes();
        test_rr_rotation();
        test_back_to_back_reads();
        test_write_read_collision();
        test_reset_in_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
